// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver FSM
// encoding, common bit-period constants and the 3-sample vote.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int CLKS_115200_100MHZ = 868;
    localparam int CLKS_9600_100MHZ   = 10417;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchroniser, per-bit phase counter and a mid-bit
// majority vote over three consecutive samples of the synchronised line.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic serial,
    input  logic run,
    output logic rx_s,
    output logic strobe,
    output logic sample,
    output logic bit_end
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [PW-1:0] PH_EARLY = PW'(H - 1);
    localparam logic [PW-1:0] PH_MID   = PW'(H);
    localparam logic [PW-1:0] PH_LATE  = PW'(H + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_BIT - 1);

    logic          sync1;
    logic [PW-1:0] phase;
    logic          tap_early;
    logic          tap_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial;
            rx_s  <= sync1;
        end
    end

    // Dropping run parks the counter at 0 so the next frame starts a fresh bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!run || phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_early <= 1'b1;
            tap_mid   <= 1'b1;
        end else begin
            if (phase == PH_EARLY) tap_early <= rx_s;
            if (phase == PH_MID)   tap_mid   <= rx_s;
        end
    end

    assign strobe  = (phase == PH_LATE);
    assign sample  = majority3(tap_early, tap_mid, rx_s);
    assign bit_end = (phase == PH_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, shift register and a held valid/ready output word
// with parity, framing, break and overrun status.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] DATA_DONE = CW'(DATA_BITS);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    rx_state_t            state, state_next;
    logic [CW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_err_q, par_err_next;
    logic                 par_bit_q, par_bit_next;
    logic                 stop_bad_q, stop_bad_next;
    logic                 run;
    logic                 deliver;
    logic                 frame_bad;
    logic                 rx_s, strobe, sample, bit_end;
    logic                 par_expected;
    logic                 accept;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .serial (RsRx),
        .run    (run),
        .rx_s   (rx_s),
        .strobe (strobe),
        .sample (sample),
        .bit_end(bit_end)
    );

    assign par_expected = (PARITY == PAR_ODD) ? ~(^shreg) : (^shreg);
    assign frame_bad    = stop_bad_q | ~sample;
    assign accept       = valid & ready;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_err_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            par_err_q  <= par_err_next;
            par_bit_q  <= par_bit_next;
            stop_bad_q <= stop_bad_next;
        end
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shreg_next    = shreg;
        par_err_next  = par_err_q;
        par_bit_next  = par_bit_q;
        stop_bad_next = stop_bad_q;
        run           = 1'b1;
        deliver       = 1'b0;
        case (state)
            S_IDLE: begin
                run = ~rx_s;
                if (!rx_s) begin
                    state_next    = S_START;
                    bit_cnt_next  = '0;
                    par_err_next  = 1'b0;
                    par_bit_next  = 1'b0;
                    stop_bad_next = 1'b0;
                end
            end
            S_START: begin
                if (strobe && sample) begin
                    state_next = S_IDLE;
                    run        = 1'b0;
                end else if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (strobe) begin
                    if (MSB_FIRST != 0) shreg_next = {shreg[DATA_BITS-2:0], sample};
                    else                shreg_next = {sample, shreg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt + CW'(1);
                end
                if (bit_end && bit_cnt == DATA_DONE) begin
                    bit_cnt_next = '0;
                    if (PARITY != PAR_NONE) state_next = S_PARITY;
                    else                    state_next = S_STOP;
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    par_bit_next = sample;
                    par_err_next = (sample != par_expected);
                end
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                // Delivery happens at the last stop decision, not the end of the bit,
                // so a start bit following immediately is still caught from IDLE.
                if (strobe) begin
                    stop_bad_next = frame_bad;
                    if (bit_cnt == STOP_LAST) begin
                        deliver      = 1'b1;
                        run          = 1'b0;
                        bit_cnt_next = '0;
                        state_next   = frame_bad ? S_WAIT_IDLE : S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + CW'(1);
                    end
                end
            end
            S_WAIT_IDLE: begin
                run = 1'b0;
                if (rx_s) state_next = S_IDLE;
            end
            default: begin
                run        = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // A new word only replaces the held one if the consumer has taken it this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (deliver) begin
            if (!valid || accept) begin
                data       <= shreg;
                valid      <= 1'b1;
                parity_err <= par_err_q;
                frame_err  <= frame_bad;
                break_det  <= frame_bad & (shreg == '0) & ~par_bit_q;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: four receivers (8N1, 8E1, 8O1, 9-bit/2-stop/MSB-first)
// each on its own serial line, checked against a queue of expected words.
module tb_uart_rx_core;

    localparam int CPB = 16;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic [3:0] flags;
        int         lat;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rx_line;
    logic [3:0] ready;
    wire  [3:0] valid, perr, ferr, brk, ovr, busy;
    wire  [7:0] data_n, data_e, data_o;
    wire  [8:0] data_9;

    int   nchecks = 0;
    int   nerrors = 0;
    int   cyc = 0;
    int   start_cyc [4];
    int   rise_cyc  [4];
    logic [3:0] valid_d = '0;
    rec_t exp_q[$];
    rec_t act_q[$];
    rec_t mon_rec;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) u_n (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_line[0]), .data(data_n), .valid(valid[0]), .ready(ready[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .break_det(brk[0]), .overrun(ovr[0]), .busy(busy[0]));
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0)) u_e (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_line[1]), .data(data_e), .valid(valid[1]), .ready(ready[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .break_det(brk[1]), .overrun(ovr[1]), .busy(busy[1]));
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)) u_o (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_line[2]), .data(data_o), .valid(valid[2]), .ready(ready[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .break_det(brk[2]), .overrun(ovr[2]), .busy(busy[2]));
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .MSB_FIRST(1)) u_9 (
        .clk(clk), .rst_n(rst_n), .RsRx(rx_line[3]), .data(data_9), .valid(valid[3]), .ready(ready[3]),
        .parity_err(perr[3]), .frame_err(ferr[3]), .break_det(brk[3]), .overrun(ovr[3]), .busy(busy[3]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] word_of(input int k);
        case (k)
            0:       return {1'b0, data_n};
            1:       return {1'b0, data_e};
            2:       return {1'b0, data_o};
            default: return data_9;
        endcase
    endfunction

    // Every accepted word is captured with its flags and rise-to-start latency.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (valid[k] && !valid_d[k]) rise_cyc[k] = cyc;
            if (valid[k] && ready[k]) begin
                mon_rec.inst  = k;
                mon_rec.data  = word_of(k);
                mon_rec.flags = {perr[k], ferr[k], brk[k], ovr[k]};
                mon_rec.lat   = rise_cyc[k] - start_cyc[k];
                act_q.push_back(mon_rec);
            end
        end
        valid_d = valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int idx, input logic b);
        rx_line[idx] = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [8:0] word, input int nbits, input bit msb,
                              input int par_mode, input bit bad_par, input int nstop,
                              input logic [1:0] stop_vals);
        logic p;
        @(posedge clk);
        #1;
        start_cyc[idx] = cyc;
        drive_bit(idx, 1'b0);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = msb ? word[nbits-1-i] : word[i];
            p = p ^ b;
            drive_bit(idx, b);
        end
        if (par_mode != 0) drive_bit(idx, ((par_mode == 1) ? ~p : p) ^ bad_par);
        for (int i = 0; i < nstop; i++) drive_bit(idx, stop_vals[i]);
        rx_line[idx] = 1'b1;
    endtask

    task automatic push_exp(input int inst, input logic [8:0] d, input logic [3:0] flags, input int lat);
        rec_t e;
        e.inst = inst; e.data = d; e.flags = flags; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(4);
        nchecks++;
        if ({valid, busy} !== 8'h00) begin
            nerrors++; $display("[TB] FAIL reset_valid_busy: got %b required 00000000", {valid, busy});
        end
        nchecks++;
        if ({perr, ferr, brk, ovr} !== 16'h0000) begin
            nerrors++; $display("[TB] FAIL reset_flags: got %h required 0000", {perr, ferr, brk, ovr});
        end
        nchecks++;
        if ({data_n, data_e, data_o, data_9} !== 33'h0) begin
            nerrors++; $display("[TB] FAIL reset_data: got %h required 0", {data_n, data_e, data_o, data_9});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_8n1();
        rec_t e, a;
        ready[0] = 1'b1;
        push_exp(0, 9'h0A5, 4'b0000, 2 + 9 * CPB + CPB / 2 + 2);
        send_frame(0, 9'h0A5, 8, 0, 0, 0, 1, 2'b11);
        wait_cycles(CPB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            nchecks++;
            if (act_q.size() == 0) begin
                nerrors++; $display("[TB] FAIL 8n1_word: no word, required data=%h", e.data);
            end else begin
                a = act_q.pop_front();
                nchecks += 3;
                if (a.inst !== e.inst || a.data !== e.data) begin
                    nerrors++; $display("[TB] FAIL 8n1_data: got %0d/%h required %0d/%h", a.inst, a.data, e.inst, e.data);
                end
                if (a.flags !== e.flags) begin
                    nerrors++; $display("[TB] FAIL 8n1_flags: got %b required %b", a.flags, e.flags);
                end
                if (a.lat !== e.lat) begin
                    nerrors++; $display("[TB] FAIL 8n1_latency: got %0d required %0d", a.lat, e.lat);
                end
            end
        end
        nchecks++;
        if (act_q.size() != 0 || busy[0] !== 1'b0) begin
            nerrors++; $display("[TB] FAIL 8n1_idle: extra words %0d busy %b required 0 and 0", act_q.size(), busy[0]);
        end
    endtask

    task automatic test_parity();
        rec_t e, a;
        ready[1] = 1'b1;
        ready[2] = 1'b1;
        push_exp(1, 9'h03C, 4'b1000, 0);
        send_frame(1, 9'h03C, 8, 0, 2, 1, 1, 2'b11);
        push_exp(2, 9'h03C, 4'b0000, 0);
        send_frame(2, 9'h03C, 8, 0, 1, 0, 1, 2'b11);
        wait_cycles(CPB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            nchecks++;
            if (act_q.size() == 0) begin
                nerrors++; $display("[TB] FAIL parity_word: no word from inst %0d, required data=%h", e.inst, e.data);
            end else begin
                a = act_q.pop_front();
                nchecks += 2;
                if (a.inst !== e.inst || a.data !== e.data) begin
                    nerrors++; $display("[TB] FAIL parity_data: got %0d/%h required %0d/%h", a.inst, a.data, e.inst, e.data);
                end
                if (a.flags !== e.flags) begin
                    nerrors++; $display("[TB] FAIL parity_flags inst %0d: got %b required %b", e.inst, a.flags, e.flags);
                end
            end
        end
    endtask

    task automatic test_glitch();
        rec_t e, a;
        int n;
        ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rx_line[0] = 1'b0;
        wait_cycles(5);
        rx_line[0] = 1'b1;
        n = 0;
        while (busy[0] && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        nchecks++;
        if (busy[0] !== 1'b0) begin
            nerrors++; $display("[TB] FAIL glitch_busy: busy %b after 12 clks, required 0", busy[0]);
        end
        wait_cycles(3 * CPB);
        nchecks++;
        if (act_q.size() != 0 || valid[0] !== 1'b0) begin
            nerrors++; $display("[TB] FAIL glitch_word: words %0d valid %b, required 0 and 0", act_q.size(), valid[0]);
            act_q.delete();
        end
        push_exp(0, 9'h055, 4'b0000, 0);
        send_frame(0, 9'h055, 8, 0, 0, 0, 1, 2'b11);
        wait_cycles(CPB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            nchecks++;
            if (act_q.size() == 0) begin
                nerrors++; $display("[TB] FAIL glitch_next_word: no word, required data=%h", e.data);
            end else begin
                a = act_q.pop_front();
                nchecks++;
                if (a.data !== e.data || a.flags !== e.flags) begin
                    nerrors++; $display("[TB] FAIL glitch_next_data: got %h/%b required %h/%b", a.data, a.flags, e.data, e.flags);
                end
            end
        end
    endtask

    task automatic test_overrun();
        rec_t e, a;
        ready[0] = 1'b0;
        send_frame(0, 9'h011, 8, 0, 0, 0, 1, 2'b11);
        send_frame(0, 9'h022, 8, 0, 0, 0, 1, 2'b11);
        wait_cycles(2);
        nchecks++;
        if ({valid[0], data_n, ovr[0]} !== {1'b1, 8'h11, 1'b1}) begin
            nerrors++; $display("[TB] FAIL overrun_hold: got valid=%b data=%h ovr=%b required 1 11 1", valid[0], data_n, ovr[0]);
        end
        push_exp(0, 9'h011, 4'b0001, 0);
        ready[0] = 1'b1;
        wait_cycles(2);
        nchecks++;
        if (valid[0] !== 1'b0 || ovr[0] !== 1'b0) begin
            nerrors++; $display("[TB] FAIL overrun_release: got valid=%b ovr=%b required 0 0", valid[0], ovr[0]);
        end
        wait_cycles(2 * CPB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            nchecks++;
            if (act_q.size() == 0) begin
                nerrors++; $display("[TB] FAIL overrun_word: no word, required data=%h", e.data);
            end else begin
                a = act_q.pop_front();
                nchecks++;
                if (a.data !== e.data || a.flags !== e.flags) begin
                    nerrors++; $display("[TB] FAIL overrun_data: got %h/%b required %h/%b", a.data, a.flags, e.data, e.flags);
                end
            end
        end
        nchecks++;
        if (act_q.size() != 0) begin
            nerrors++; $display("[TB] FAIL overrun_dropped: got %0d extra words required 0", act_q.size());
            act_q.delete();
        end
    endtask

    task automatic test_break();
        rec_t e, a;
        ready[0] = 1'b1;
        push_exp(0, 9'h000, 4'b0110, 0);
        @(posedge clk);
        #1;
        rx_line[0] = 1'b0;
        wait_cycles(40 * CPB);
        rx_line[0] = 1'b1;
        wait_cycles(2 * CPB);
        push_exp(0, 9'h07E, 4'b0000, 0);
        send_frame(0, 9'h07E, 8, 0, 0, 0, 1, 2'b11);
        wait_cycles(CPB);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            nchecks++;
            if (act_q.size() == 0) begin
                nerrors++; $display("[TB] FAIL break_word: no word, required data=%h", e.data);
            end else begin
                a = act_q.pop_front();
                nchecks++;
                if (a.data !== e.data || a.flags !== e.flags) begin
                    nerrors++; $display("[TB] FAIL break_data: got %h/%b required %h/%b", a.data, a.flags, e.data, e.flags);
                end
            end
        end
        nchecks++;
        if (act_q.size() != 0) begin
            nerrors++; $display("[TB] FAIL break_count: got %0d extra words required 0", act_q.size());
            act_q.delete();
        end
    endtask

    task automatic test_nine_bit();
        ready[3] = 1'b0;
        send_frame(3, 9'h1A3, 9, 1, 0, 0, 2, 2'b01);
        wait_cycles(2);
        nchecks++;
        if ({valid[3], data_9} !== {1'b1, 9'h1A3}) begin
            nerrors++; $display("[TB] FAIL nine_data: got valid=%b data=%h required 1 1a3", valid[3], data_9);
        end
        nchecks++;
        if ({perr[3], ferr[3], brk[3], ovr[3]} !== 4'b0100) begin
            nerrors++; $display("[TB] FAIL nine_flags: got %b required 0100", {perr[3], ferr[3], brk[3], ovr[3]});
        end
        wait_cycles(CPB);
    endtask

    task automatic test_reset_mid_frame();
        fork
            send_frame(3, 9'h0F0, 9, 1, 0, 0, 2, 2'b11);
            begin
                repeat (5 * CPB + 7) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                nchecks++;
                if ({valid[3], busy[3], perr[3], ferr[3], brk[3], ovr[3], data_9} !== 15'h0) begin
                    nerrors++; $display("[TB] FAIL midreset_outputs: got %b/%h required all 0",
                                        {valid[3], busy[3], perr[3], ferr[3], brk[3], ovr[3]}, data_9);
                end
            end
        join
        wait_cycles(8);
        @(negedge clk);
        rst_n = 1'b1;
        ready[3] = 1'b1;
        wait_cycles(4 * CPB);
        nchecks++;
        if (valid[3] !== 1'b0 || act_q.size() != 0) begin
            nerrors++; $display("[TB] FAIL midreset_no_word: got valid=%b words=%0d required 0 0", valid[3], act_q.size());
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_line = '1;
        ready   = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_nine_bit();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
